// File: rtl/mul32_arbiter.sv
// Round-robin share of one 32x32 unsigned multiplier; accept->rsp_valid in EXEC_CYCLES+1 cycles.
// One op in flight; result held in DONE until rsp_ready, req_ready low outside IDLE.
module mul32_arbiter #(
  parameter  int NREQ        = 4,
  parameter  int EXEC_CYCLES = 2,
  localparam int IDW         = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [63:0]          rsp_data,
  output logic                 busy
);

  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] id;
  logic [CW-1:0]  cnt;
  op_t            op;
  op_t            req_op [NREQ];

  logic           grant_vld;
  logic [IDW-1:0] grant;
  logic [IDW:0]   scan_sum;
  logic [IDW-1:0] scan_idx;
  logic [63:0]    product;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_op[i] = {req_a[32*i +: 32], req_b[32*i +: 32]};
  end

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (scan_sum >= (IDW+1)'(NREQ)) begin
        scan_sum = scan_sum - (IDW+1)'(NREQ);
      end
      scan_idx = scan_sum[IDW-1:0];
      if (!grant_vld && req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant     = scan_idx;
      end
    end
  end

  assign req_ready = (rst_n && state == IDLE && grant_vld)
                   ? ({{(NREQ-1){1'b0}}, 1'b1} << grant) : '0;

  // Multicycle path: operands stay frozen in op for the whole EXEC window.
  assign product = 64'(op.a) * 64'(op.b);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id        <= '0;
      cnt       <= '0;
      op        <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            op     <= req_op[grant];
            id     <= grant;
            rr_ptr <= (grant == IDW'(NREQ-1)) ? '0 : grant + 1'b1;
            cnt    <= CW'(EXEC_CYCLES-1);
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_data  <= product;
            rsp_id    <= id;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul32_arbiter.sv
// Directed bench for mul32_arbiter: latency, products, round-robin order, backpressure, reset abort.
module tb_mul32_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [63:0]       rsp_data;
  logic              busy;

  int checks;
  int errors;

  mul32_arbiter #(.NREQ(NREQ), .EXEC_CYCLES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_valid[i]      = 1'b1;
  endtask

  // Called in an IDLE cycle with requests settled; returns in the first rsp_valid cycle.
  task automatic run_op(input string tag, input int gid, input logic [63:0] prod);
    int n;
    chk({tag, "_ready"}, 64'(req_ready), 64'(1) << gid);
    chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) req_valid[gid] = 1'b0;
    end while (!rsp_valid && n < 20);
    chk({tag, "_latency"}, 64'(n), 64'd3);
    chk({tag, "_data"}, rsp_data, prod);
    chk({tag, "_id"}, 64'(rsp_id), 64'(gid));
    chk({tag, "_ready_done"}, 64'(req_ready), 64'd0);
    chk({tag, "_busy_done"}, 64'(busy), 64'd1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // Reset with a pending request: no accept strobe, outputs cleared.
    set_req(0, 32'd3, 32'd5);
    tick();
    tick();
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_id", 64'(rsp_id), 64'd0);
    chk("rst_data", rsp_data, 64'd0);

    // Single request, then operand extremes.
    rst_n = 1'b1;
    #1;
    run_op("t1", 0, 64'd15);
    tick();
    set_req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    #1;
    run_op("t2_max", 0, 64'hFFFF_FFFE_0000_0001);
    tick();
    set_req(1, 32'h0, 32'hDEAD_BEEF);
    #1;
    run_op("t2_zero", 1, 64'd0);

    // rr_ptr is now 2: requesters 0 and 1 are served as 0 then 1.
    tick();
    set_req(0, 32'd7, 32'd9);
    set_req(1, 32'h0001_0000, 32'h0001_0000);
    #1;
    run_op("t4_first", 0, 64'd63);
    tick();
    run_op("t4_second", 1, 64'h1_0000_0000);

    // Reset while a result is held: registered outputs cleared.
    rst_n = 1'b0;
    tick();
    chk("rst2_valid", 64'(rsp_valid), 64'd0);
    chk("rst2_id", 64'(rsp_id), 64'd0);
    chk("rst2_data", rsp_data, 64'd0);
    chk("rst2_busy", 64'(busy), 64'd0);

    // All four held from reset: served 0,1,2,3 with 4-cycle spacing.
    set_req(0, 32'd2, 32'd3);
    set_req(1, 32'h8000_0000, 32'd2);
    set_req(2, 32'hFFFF_FFFF, 32'd1);
    set_req(3, 32'h0001_0000, 32'h0000_FFFF);
    #1;
    chk("rst2_ready", 64'(req_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    run_op("t3_id0", 0, 64'd6);
    tick();
    run_op("t3_id1", 1, 64'h1_0000_0000);
    tick();
    run_op("t3_id2", 2, 64'h0000_0000_FFFF_FFFF);
    tick();
    run_op("t3_id3", 3, 64'h0000_0000_FFFF_0000);

    // Backpressure: result held 6 cycles in DONE while requester 0 waits.
    tick();
    rsp_ready = 1'b0;
    set_req(2, 32'd6, 32'd7);
    #1;
    run_op("t5", 2, 64'd42);
    set_req(0, 32'd1, 32'd1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t5_hold_valid", 64'(rsp_valid), 64'd1);
      chk("t5_hold_data", rsp_data, 64'd42);
      chk("t5_hold_id", 64'(rsp_id), 64'd2);
      chk("t5_hold_ready", 64'(req_ready), 64'd0);
      chk("t5_hold_busy", 64'(busy), 64'd1);
    end
    tick();
    rsp_ready = 1'b1;
    #1;
    chk("t5_no_same_cycle_grant", 64'(req_ready), 64'd0);
    tick();
    chk("t5_released", 64'(rsp_valid), 64'd0);
    run_op("t5_regrant", 0, 64'd1);

    // Reset during EXEC: op from requester 2 aborted, rr_ptr back to 0.
    tick();
    set_req(2, 32'd5, 32'd5);
    set_req(0, 32'd11, 32'd11);
    set_req(3, 32'd4, 32'd4);
    #1;
    chk("t6_grant2", 64'(req_ready), 64'b0100);
    tick();
    req_valid[2] = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("t6_valid", 64'(rsp_valid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    run_op("t6_after", 0, 64'd121);
    tick();
    run_op("t6_next", 3, 64'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
